ifid_fetch: RTL
===============

IFID_FETCH -- requirements
Module: ifid_fetch

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: PCStall  input  1  hazard stall; hold PC and IF/ID contents.
REQ-004 SHALL have port: BranchTaken  input  1  resolved taken branch; redirect and flush.
REQ-005 SHALL have port: BranchTarget  input  8  word address of the branch destination.
REQ-006 SHALL have port: ImemAddr  output  8  instruction memory address; equals current PC, combinational.
REQ-007 SHALL have port: ImemData  input  16  instruction word at ImemAddr, valid in the same cycle (asynchronous ROM).
REQ-008 SHALL have port: IFID  output  16  registered instruction presented to decode and hazard control.
REQ-009 SHALL have port: IFIDPC  output  8  registered PC+1 of the instruction in IFID.
REQ-010 SHALL have port: IFIDValid  output  1  IFID holds a real fetched instruction (0 = bubble).
REQ-011 SHALL have port: Halted  output  1  fetch state is HALT.
REQ-012 SHALL have port: StallCount  output  16  cycles spent stalled (see Configuration).

Function
REQ-013 SHALL keep a 2-state FSM: RUN, HALT.
REQ-014 SHALL evaluate each rising edge with priority reset > BranchTaken > HALT hold > PCStall > normal fetch.
REQ-015 BranchTaken=1 (any state, including PCStall=1): PC<=BranchTarget; IFID<=NOP_INSTR; IFIDPC<=0; IFIDValid<=0; state<=RUN.
REQ-016 RUN, PCStall=1, no branch: PC, IFID, IFIDPC, IFIDValid SHALL all hold their values.
REQ-017 RUN, normal fetch: PC<=PC+1; IFID<=ImemData; IFIDPC<=PC+1; IFIDValid<=1.
REQ-018 PC increment SHALL be 8-bit modulo: 8'hFF -> 8'h00, no flag.
REQ-019 Normal fetch of ImemData==HALT_INSTR: instruction SHALL be latched into IFID as in REQ-017, PC SHALL NOT increment, state<=HALT.
REQ-020 HALT, no branch: PC holds; IFID<=NOP_INSTR; IFIDValid<=0 from the cycle after entry; PCStall ignored.
REQ-021 Halted SHALL be 1 exactly while state==HALT.
REQ-022 Fetch latency: instruction at PC visible on IFID one cycle after PC presented on ImemAddr.

Reset
REQ-023 On reset=1 at an edge: PC=8'h00, IFID=NOP_INSTR, IFIDPC=8'h00, IFIDValid=0, state=RUN, StallCount=16'h0000, overriding BranchTaken and PCStall.
REQ-024 Reset asserted mid-stall or in HALT SHALL give the same result as REQ-023; fetch from address 0 begins on the first edge with reset=0 and PCStall=0.

Configuration
REQ-025 With STALL_COUNT_EN defined: StallCount SHALL increment by 1 on each edge where state==RUN, PCStall=1, BranchTaken=0, reset=0; saturate at 16'hFFFF.
REQ-026 Without STALL_COUNT_EN: counter logic SHALL be omitted and StallCount SHALL be driven constant 16'h0000; port list unchanged.

Structure
REQ-027 Shared package pmips_pkg SHALL hold PC_W=8, INSTR_W=16, NOP_INSTR=16'h0000, HALT_INSTR=16'hFFFF, FSM state encodings.
REQ-028 PC register SHALL be a sub-module pc_reg (load / hold / increment, synchronous reset); IF/ID register and FSM stay in ifid_fetch.

Verification
REQ-029 Reset, then 3 free-running cycles with ImemData=16'h1234,16'h2345,16'h3456 -> ImemAddr 00,01,02,03; IFID follows one cycle behind; IFIDPC 01,02,03; IFIDValid=1.
REQ-030 PC=05, PCStall=1 for 3 cycles -> ImemAddr stays 05, IFID/IFIDPC/IFIDValid unchanged, StallCount +3 (macro on) or 0 (macro off).
REQ-031 PC=07 with PCStall=1 and BranchTaken=1, BranchTarget=8'h40 -> next cycle ImemAddr=40, IFID=16'h0000, IFIDValid=0; StallCount unchanged.
REQ-032 PC=8'hFF normal fetch -> ImemAddr=00 next cycle, IFIDPC=00.
REQ-033 ImemData=16'hFFFF at PC=10 -> IFID=FFFF, Halted=1, ImemAddr stays 10, next IFID=0000 IFIDValid=0; then BranchTaken to 8'h20 -> Halted=0, ImemAddr=20.
REQ-034 Reset asserted while Halted=1 and PCStall=1 -> next cycle PC=00, Halted=0, IFIDValid=0, StallCount=0.

Source files
------------

// File: rtl/pmips_pkg.sv
// Shared widths, instruction constants and fetch FSM encoding for the pmips front end.
package pmips_pkg;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // Wraps 8'hFF -> 8'h00 silently.
  function automatic logic [PC_W-1:0] pc_plus1(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction
endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, priority load > increment > hold.
module pc_reg
  import pmips_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clock) begin
    if (reset)     pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc_plus1(pc);
  end

endmodule

// File: rtl/ifid_fetch.sv
// Instruction fetch stage with IF/ID pipeline register and RUN/HALT control.
// Optional STALL_COUNT_EN macro adds a saturating stall-cycle counter on StallCount.
//
// state   | meaning
// ST_RUN  | fetching: advance, stall or redirect each cycle
// ST_HALT | halt instruction seen; PC frozen, bubbles issued until a branch
module ifid_fetch
  import pmips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               PCStall,
  input  logic               BranchTaken,
  input  logic [PC_W-1:0]    BranchTarget,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] IFID,
  output logic [PC_W-1:0]    IFIDPC,
  output logic               IFIDValid,
  output logic               Halted,
  output logic [15:0]        StallCount
);

  fetch_state_e       state, state_nxt;
  logic [PC_W-1:0]    pc;
  logic               pc_load, pc_inc;
  logic [INSTR_W-1:0] ifid_nxt;
  logic [PC_W-1:0]    ifidpc_nxt;
  logic               valid_nxt;

  pc_reg u_pc_reg (
    .clock    (clock),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (BranchTarget),
    .pc       (pc)
  );

  assign ImemAddr = pc;
  assign Halted   = (state == ST_HALT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RUN;
      IFID      <= NOP_INSTR;
      IFIDPC    <= '0;
      IFIDValid <= 1'b0;
    end else begin
      state     <= state_nxt;
      IFID      <= ifid_nxt;
      IFIDPC    <= ifidpc_nxt;
      IFIDValid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    ifid_nxt   = IFID;
    ifidpc_nxt = IFIDPC;
    valid_nxt  = IFIDValid;
    if (BranchTaken) begin
      pc_load    = 1'b1;
      ifid_nxt   = NOP_INSTR;
      ifidpc_nxt = '0;
      valid_nxt  = 1'b0;
      state_nxt  = ST_RUN;
    end else if (state == ST_HALT) begin
      ifid_nxt  = NOP_INSTR;
      valid_nxt = 1'b0;
    end else if (!PCStall) begin
      ifid_nxt   = ImemData;
      ifidpc_nxt = pc_plus1(pc);
      valid_nxt  = 1'b1;
      // The halt word is still delivered to decode, but the PC stays on it.
      if (ImemData == HALT_INSTR) state_nxt = ST_HALT;
      else                        pc_inc    = 1'b1;
    end
  end

`ifdef STALL_COUNT_EN
  logic        stall_inc;
  logic [15:0] stall_cnt;

  assign stall_inc = (state == ST_RUN) && PCStall && !BranchTaken;

  always_ff @(posedge clock) begin
    if (reset)                                   stall_cnt <= '0;
    else if (stall_inc && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = 16'h0000;
`endif

endmodule
